rvga_mem_arbiter: RTL and testbench
===================================

# rvga_mem_arbiter

Shares one unified single-port memory between the instruction-fetch and data-memory requesters of the rvga pipeline. The top level places it between the core's `imem_*`/`dmem_*` ports and the external memory. It grants one access at a time, gives data accesses priority with a starvation bound for fetch, and converts a missing memory response into a sticky error. It also converts the core's per-access handshakes into a single registered memory request.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles a granted access may wait for `mem_resp_v_i` before the error state is entered; legal range 1..65535.
- `STARVE_LIMIT`, default 4: consecutive data grants taken while a fetch was pending, after which a pending fetch wins; legal range 1..255.

Ports (all `rvga_word` = 32 bits):
- `clk_i` in 1: the single clock; all state on rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `imem_req_v_i` in 1: fetch request, level, held until `imem_resp_v_o`.
- `imem_addr_i` in 32: fetch address.
- `imem_data_o` out 32: fetch data.
- `imem_resp_v_o` out 1: fetch complete.
- `dmem_r_v_i` in 1: load request, level.
- `dmem_w_v_i` in 1: store request, level.
- `dmem_addr_i` in 32: load/store address.
- `dmem_data_i` in 32: store data.
- `dmem_data_o` out 32: load data.
- `dmem_resp_v_o` out 1: data access complete.
- `mem_r_v_o` out 1: memory read strobe.
- `mem_w_v_o` out 1: memory write strobe.
- `mem_addr_o` out 32: memory address.
- `mem_data_o` out 32: memory write data.
- `mem_data_i` in 32: memory read data.
- `mem_resp_v_i` in 1: memory access complete.
- `busy_o` out 1: an access is granted.
- `err_v_o` out 1: sticky timeout error.

## Operation
- FSM states: IDLE, IMEM, DMEM, ERR.
- Reset (`rst_i`=0, any time, including mid-access):
  - state goes to IDLE; timeout and starvation counters clear.
  - all `mem_*_o`, `busy_o` and `err_v_o` go to 0.
  - An in-flight access is abandoned and gets no response.
- IDLE: samples requests; a data request is `dmem_r_v_i | dmem_w_v_i`.
  - Only fetch pending: grant fetch, go to IMEM.
  - Only data pending: grant data, go to DMEM.
  - Both pending: grant fetch if the starvation counter equals `STARVE_LIMIT`, otherwise grant data.
  - On grant, the address is registered into `mem_addr_o`. For a data grant, the operation and store data are registered too (`mem_data_o` = `dmem_data_i` for a write, else 0).
  - `dmem_r_v_i` and `dmem_w_v_i` both high is treated as a write only.
- IMEM/DMEM:
  - `busy_o` = 1.
  - The registered strobe is held: `mem_r_v_o` for a fetch or load, `mem_w_v_o` for a store.
  - Address and data stay stable until `mem_resp_v_i`.
- Response cycle (`mem_resp_v_i`=1 in IMEM/DMEM):
  - Combinationally forward `mem_resp_v_i` to the granted requester's `*_resp_v_o`, and `mem_data_i` to its `*_data_o`.
  - The non-granted requester's response stays 0.
  - Drop the strobes and return to IDLE at the next edge.
- Data outputs: `imem_data_o` = `mem_data_i` when in IMEM, else 0. `dmem_data_o` = `mem_data_i` when in DMEM, else 0.
- `mem_resp_v_i` seen in IDLE or ERR is ignored and never forwarded.
- Starvation counter (8 bits):
  - +1 on each data grant made while `imem_req_v_i`=1, saturating at `STARVE_LIMIT`.
  - Cleared on every fetch grant.
  - Unchanged on a data grant with no fetch pending.
- Timeout counter (16 bits):
  - Cleared on grant; +1 each cycle in IMEM/DMEM without `mem_resp_v_i`.
  - On reaching `TIMEOUT_CYCLES`, go to ERR.
  - If `mem_resp_v_i` arrives in the same cycle the limit is reached, the response wins: normal completion, no error.
- ERR:
  - All strobes, `busy_o` and responses are 0; `err_v_o` = 1.
  - Remains in ERR until reset. Requests are ignored.

## Timing
- Request visible in IDLE at cycle N: strobe asserted from N+1.
- Response at cycle M: requester's `resp_v` and data valid in M (combinational); IDLE at M+1; next strobe at M+2 at the earliest.
- Memory answering in the strobe's first cycle gives a best-case throughput of one access per 2 cycles.
- Requesters update or drop their request at the edge after seeing `resp_v`; IDLE re-samples in that same cycle. No stale re-grant occurs because state is IDLE only after the edge.
- Timeout: with no response, ERR is entered at the edge ending the `TIMEOUT_CYCLES`-th waiting cycle. `err_v_o` rises the cycle after.

## Test plan
- Single fetch, addr 0x100, memory replies 0xDEADBEEF two cycles after the strobe -> `mem_r_v_o`=1 with addr 0x100 for 3 cycles; `imem_resp_v_o`=1 with 0xDEADBEEF in the response cycle only; `dmem_resp_v_o` stays 0.
- Store to 0x200 with data 0x12345678 and a simultaneous fetch, `STARVE_LIMIT`=4 -> store is granted first (`mem_w_v_o`, 0x200/0x12345678); fetch is granted on the following IDLE.
- Continuous loads with a continuously pending fetch, `STARVE_LIMIT`=4 -> exactly 4 load grants, then a fetch grant; the pattern repeats.
- No `mem_resp_v_i` with `TIMEOUT_CYCLES`=8 -> strobe held for 8 cycles, then strobe drops, `err_v_o`=1 and stays high; new requests are ignored. Repeat with the response in the 8th cycle -> normal completion, `err_v_o`=0.
- `rst_i` pulled low mid-DMEM -> all outputs 0 immediately (asynchronously). After release, a pending fetch is granted from IDLE; no stale `dmem_resp_v_o`.
- Spurious `mem_resp_v_i` in IDLE, and `dmem_r_v_i`=`dmem_w_v_i`=1 -> no response forwarded for the spurious pulse; the dual request issues `mem_w_v_o` only.

Source files
------------

// File: rtl/rvga_mem_arbiter.sv
// rtl/rvga_mem_arbiter.sv - single-port memory arbiter between rvga fetch and data requesters
// Data wins by default; a pending fetch wins once STARVE_LIMIT data grants passed it by.
module rvga_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_req_v_i,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] imem_data_o,
  output logic        imem_resp_v_o,
  input  logic        dmem_r_v_i,
  input  logic        dmem_w_v_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_data_i,
  output logic [31:0] dmem_data_o,
  output logic        dmem_resp_v_o,
  output logic        mem_r_v_o,
  output logic        mem_w_v_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_resp_v_i,
  output logic        busy_o,
  output logic        err_v_o
);

  typedef enum logic [1:0] {IDLE, IMEM, DMEM, ERR} state_e;

  localparam logic [7:0]  STARVE_MAX = 8'(STARVE_LIMIT);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  starve_q, starve_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        dmem_req;

  assign dmem_req = dmem_r_v_i | dmem_w_v_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      starve_q <= '0;
      tmo_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    tmo_d    = tmo_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    unique case (state_q)
      IDLE: begin
        if (imem_req_v_i && (!dmem_req || starve_q == STARVE_MAX)) begin
          state_d  = IMEM;
          starve_d = '0;
          tmo_d    = '0;
          addr_d   = imem_addr_i;
          wdata_d  = '0;
          we_d     = 1'b0;
        end else if (dmem_req) begin
          // A simultaneous read+write request is issued as a write.
          state_d = DMEM;
          tmo_d   = '0;
          addr_d  = dmem_addr_i;
          we_d    = dmem_w_v_i;
          wdata_d = dmem_w_v_i ? dmem_data_i : '0;
          if (imem_req_v_i && starve_q < STARVE_MAX) begin
            starve_d = starve_q + 8'd1;
          end
        end
      end
      IMEM, DMEM: begin
        if (mem_resp_v_i) begin
          state_d = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o        = (state_q == IMEM) || (state_q == DMEM);
  assign mem_r_v_o     = (state_q == IMEM) || ((state_q == DMEM) && !we_q);
  assign mem_w_v_o     = (state_q == DMEM) && we_q;
  assign mem_addr_o    = addr_q;
  assign mem_data_o    = wdata_q;
  assign imem_resp_v_o = (state_q == IMEM) && mem_resp_v_i;
  assign dmem_resp_v_o = (state_q == DMEM) && mem_resp_v_i;
  assign imem_data_o   = (state_q == IMEM) ? mem_data_i : '0;
  assign dmem_data_o   = (state_q == DMEM) ? mem_data_i : '0;
  assign err_v_o       = (state_q == ERR);

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// tb/tb_rvga_mem_arbiter.sv - self-checking bench for rvga_mem_arbiter
module tb_rvga_mem_arbiter;

  localparam int TMO = 8;
  localparam int SL  = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_v_i;
  logic [31:0] imem_addr_i;
  logic [31:0] imem_data_o;
  logic        imem_resp_v_o;
  logic        dmem_r_v_i;
  logic        dmem_w_v_i;
  logic [31:0] dmem_addr_i;
  logic [31:0] dmem_data_i;
  logic [31:0] dmem_data_o;
  logic        dmem_resp_v_o;
  logic        mem_r_v_o;
  logic        mem_w_v_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_resp_v_i;
  logic        busy_o;
  logic        err_v_o;

  rvga_mem_arbiter #(.TIMEOUT_CYCLES(TMO), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_v_i(imem_req_v_i), .imem_addr_i(imem_addr_i),
    .imem_data_o(imem_data_o), .imem_resp_v_o(imem_resp_v_o),
    .dmem_r_v_i(dmem_r_v_i), .dmem_w_v_i(dmem_w_v_i),
    .dmem_addr_i(dmem_addr_i), .dmem_data_i(dmem_data_i),
    .dmem_data_o(dmem_data_o), .dmem_resp_v_o(dmem_resp_v_o),
    .mem_r_v_o(mem_r_v_o), .mem_w_v_o(mem_w_v_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_resp_v_i(mem_resp_v_i),
    .busy_o(busy_o), .err_v_o(err_v_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Requester model: pending transactions and the memory contents
  bit          f_pend, d_pend, d_rd, d_wr;
  logic [31:0] f_addr, d_addr, d_wdata;
  int          starve_m;
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] obs_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_reqs();
    imem_req_v_i = f_pend;
    imem_addr_i  = f_addr;
    dmem_r_v_i   = d_pend & d_rd;
    dmem_w_v_i   = d_pend & d_wr;
    dmem_addr_i  = d_addr;
    dmem_data_i  = d_wdata;
  endtask

  task automatic mem_read(input logic [31:0] a, output logic [31:0] v);
    if (!mem_m.exists(a)) mem_m[a] = $urandom;
    v = mem_m[a];
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_strb"}, 32'({mem_r_v_o, mem_w_v_o}), 0);
    check({tag, "_iresp"}, 32'(imem_resp_v_o), 0);
    check({tag, "_dresp"}, 32'(dmem_resp_v_o), 0);
  endtask

  task automatic apply_reset();
    rst_i = 1'b0;
    f_pend = 0;
    d_pend = 0;
    drive_reqs();
    mem_resp_v_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_quiet("rst");
    check("rst_err", 32'(err_v_o), 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_wdata", mem_data_o, 0);
    step();
    rst_i = 1'b1;
    starve_m = 0;
  endtask

  // One IDLE cycle plus, if anything is pending, one complete access answered in its lat-th cycle
  task automatic do_round(input int lat);
    bit          fw;
    logic [31:0] rd;
    int          l;
    l = lat;
    drive_reqs();
    mem_resp_v_i = 1'($urandom_range(0, 1));
    mem_data_i   = $urandom;
    @(negedge clk_i);
    check_quiet("idle");
    check("idle_err", 32'(err_v_o), 0);
    if (!f_pend && !d_pend) begin
      step();
      mem_resp_v_i = 1'b0;
    end else begin
      fw = (f_pend && d_pend) ? (starve_m == SL) : f_pend;
      if (fw) starve_m = 0;
      else if (f_pend && starve_m < SL) starve_m++;
      step();
      mem_resp_v_i = 1'b0;
      if (l == 0) l = $urandom_range(1, 5);
      if (fw) mem_read(f_addr, rd);
      else if (!d_wr) mem_read(d_addr, rd);
      else begin
        rd = $urandom;
        mem_m[d_addr] = d_wdata;
      end
      for (int k = 1; k <= l; k++) begin
        mem_resp_v_i = (k == l);
        mem_data_i   = (k == l) ? rd : $urandom;
        @(negedge clk_i);
        if (k == 1) obs_addr = mem_addr_o;
        check("strobe", 32'({mem_r_v_o, mem_w_v_o}), (!fw && d_wr) ? 32'd1 : 32'd2);
        check("addr", mem_addr_o, fw ? f_addr : d_addr);
        check("wdata", mem_data_o, (!fw && d_wr) ? d_wdata : 32'd0);
        check("busy", 32'(busy_o), 1);
        check("iresp", 32'(imem_resp_v_o), 32'(fw && k == l));
        check("dresp", 32'(dmem_resp_v_o), 32'(!fw && k == l));
        check("idata", imem_data_o, fw ? mem_data_i : 32'd0);
        check("ddata", dmem_data_o, fw ? 32'd0 : mem_data_i);
        step();
      end
      mem_resp_v_i = 1'b0;
      if (fw) f_pend = 0;
      else d_pend = 0;
    end
  endtask

  task automatic new_reqs();
    int sel;
    if (!f_pend && $urandom_range(0, 2) != 0) begin
      f_pend = 1;
      f_addr = 32'h100 + 32'($urandom_range(0, 7)) * 4;
    end
    if (!d_pend && $urandom_range(0, 2) != 0) begin
      d_pend  = 1;
      sel     = $urandom_range(0, 2);
      d_rd    = (sel != 1);
      d_wr    = (sel != 0);
      d_addr  = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      d_wdata = $urandom;
    end
  endtask

  initial begin
    rst_i = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0; d_rd = 0; d_wr = 0;
    mem_data_i = '0;
    apply_reset();

    // Single fetch answered two cycles after the strobe
    mem_m[32'h100] = 32'hDEADBEEF;
    f_pend = 1; f_addr = 32'h100;
    do_round(3);

    // Store against a simultaneous fetch: store first, fetch next
    f_pend = 1; f_addr = 32'h104;
    d_pend = 1; d_rd = 0; d_wr = 1; d_addr = 32'h200; d_wdata = 32'h12345678;
    do_round(1);
    check("tp2_store_first", obs_addr, 32'h200);
    do_round(1);
    check("tp2_fetch_next", obs_addr, 32'h104);

    // Starvation pattern: four loads, then one fetch, repeating
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      f_pend = 1; f_addr = 32'h1000_0000;
      d_pend = 1; d_rd = 1; d_wr = 0; d_addr = 32'h2000_0000;
      do_round(1);
      check("starve_pat", 32'(obs_addr[31:28]), (i % 5 == 4) ? 32'd1 : 32'd2);
    end

    // Dual read+write request and a spurious response in IDLE
    apply_reset();
    mem_resp_v_i = 1'b1;
    mem_data_i   = 32'hBAD0BAD0;
    @(negedge clk_i);
    check_quiet("spur");
    step();
    d_pend = 1; d_rd = 1; d_wr = 1; d_addr = 32'h300; d_wdata = 32'hA5A5_0001;
    do_round(2);

    // Randomised traffic
    apply_reset();
    repeat (200) begin
      new_reqs();
      do_round(0);
    end

    // Timeout: no response for TMO cycles
    apply_reset();
    d_pend = 1; d_rd = 1; d_wr = 0; d_addr = 32'h400; f_pend = 0;
    drive_reqs();
    step();
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk_i);
      check("tmo_strobe", 32'({mem_r_v_o, mem_w_v_o}), 2);
      check("tmo_err_low", 32'(err_v_o), 0);
      step();
    end
    f_pend = 1; f_addr = 32'h500;
    for (int k = 0; k < 6; k++) begin
      drive_reqs();
      mem_resp_v_i = 1'(k & 1);
      @(negedge clk_i);
      check("err_sticky", 32'(err_v_o), 1);
      check_quiet("err");
      step();
    end
    apply_reset();
    check("err_cleared", 32'(err_v_o), 0);

    // Response in the last allowed cycle completes normally
    d_pend = 1; d_rd = 1; d_wr = 0; d_addr = 32'h404;
    do_round(TMO);
    do_round(1);

    // Reset asserted in the middle of a store
    apply_reset();
    d_pend = 1; d_rd = 0; d_wr = 1; d_addr = 32'h600; d_wdata = 32'hCAFE_F00D;
    f_pend = 1; f_addr = 32'h700;
    starve_m = SL;
    drive_reqs();
    step();
    @(negedge clk_i);
    check("mid_strobe", 32'({mem_r_v_o, mem_w_v_o}), 1);
    mem_resp_v_i = 1'b1;
    #1 rst_i = 1'b0;
    #1;
    check_quiet("arst");
    check("arst_addr", mem_addr_o, 0);
    check("arst_wdata", mem_data_o, 0);
    check("arst_err", 32'(err_v_o), 0);
    mem_resp_v_i = 1'b0;
    d_pend = 0;
    step();
    rst_i = 1'b1;
    starve_m = 0;
    do_round(2);
    check("post_rst_fetch", obs_addr, 32'h700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
